// File: rtl/pulse_stretcher.sv
// Converts single-cycle event strobes into WIDTH-cycle pulses separated by at least GAP low
// cycles; strobes arriving mid-pulse are queued in a saturating pending counter.
module pulse_stretcher #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned GAP      = 2,
   parameter int unsigned PEND_MAX = 7
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in,
   input  logic                          clr_ovf,
   output logic                          q,
   output logic                          busy,
   output logic [$clog2(PEND_MAX+1)-1:0] pend,
   output logic                          ovf
);

   localparam int unsigned WW = $clog2(WIDTH + 1);
   localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam int unsigned PW = $clog2(PEND_MAX + 1);

   localparam logic [WW-1:0] WLAST = WW'(WIDTH);
   localparam logic [GW-1:0] GLAST = GW'(GAP);
   localparam logic [PW-1:0] PFULL = PW'(PEND_MAX);

   if (WIDTH < 1) begin : g_bad_width
      $error("pulse_stretcher: WIDTH must be >= 1");
   end
   if (PEND_MAX < 1) begin : g_bad_pend
      $error("pulse_stretcher: PEND_MAX must be >= 1");
   end

   typedef enum logic [1:0] {StIdle, StHigh, StGap} state_t;

   state_t          state_q, state_d;
   logic [WW-1:0]   wcnt_q, wcnt_d;
   logic [GW-1:0]   gcnt_q, gcnt_d;
   logic [PW-1:0]   pend_q, pend_d;
   logic            ovf_q, ovf_d;
   logic            q_q;
   logic            gap_exit;
   logic            queue_evt;

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      gcnt_d    = gcnt_q;
      pend_d    = pend_q;
      ovf_d     = ovf_q;
      gap_exit  = 1'b0;
      queue_evt = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (in) begin
               state_d = StHigh;
               wcnt_d  = WW'(1);
            end
         end
         StHigh: begin
            if (wcnt_q == WLAST) begin
               if (GAP > 0) begin
                  state_d   = StGap;
                  gcnt_d    = GW'(1);
                  queue_evt = in;
               end else begin
                  gap_exit = 1'b1;
               end
            end else begin
               wcnt_d    = wcnt_q + WW'(1);
               queue_evt = in;
            end
         end
         StGap: begin
            if (gcnt_q == GLAST) begin
               gap_exit = 1'b1;
            end else begin
               gcnt_d    = gcnt_q + GW'(1);
               queue_evt = in;
            end
         end
         default: state_d = StIdle;
      endcase

      // An event on the exit cycle either replaces the pending decrement or launches directly,
      // so it can never overflow.
      if (gap_exit) begin
         if ((pend_q != '0) || in) begin
            state_d = StHigh;
            wcnt_d  = WW'(1);
            if ((pend_q != '0) && !in) begin
               pend_d = pend_q - PW'(1);
            end
         end else begin
            state_d = StIdle;
         end
      end

      if (clr_ovf) begin
         ovf_d = 1'b0;
      end
      if (queue_evt) begin
         if (pend_q == PFULL) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         wcnt_q  <= '0;
         gcnt_q  <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         q_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         gcnt_q  <= gcnt_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         q_q     <= (state_d == StHigh);
      end
   end

   assign q    = q_q;
   assign busy = (state_q != StIdle);
   assign pend = pend_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: three configurations share one stimulus stream and are
// checked against a pulse-schedule model (list of pulse start times per configuration).
module tb_pulse_stretcher;

   localparam int NI = 3;
   localparam int PW_A [NI] = '{4, 4, 4};
   localparam int PG_A [NI] = '{2, 2, 0};
   localparam int PM_A [NI] = '{7, 3, 7};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in = 1'b0;
   logic clr_ovf = 1'b0;

   logic [NI-1:0] dq, dbusy, dovf;
   logic [2:0]    p0, p2;
   logic [1:0]    p1;

   pulse_stretcher u_dflt (
      .clk(clk), .rst_n(rst_n), .in(in), .clr_ovf(clr_ovf),
      .q(dq[0]), .busy(dbusy[0]), .pend(p0), .ovf(dovf[0])
   );

   pulse_stretcher #(.PEND_MAX(3)) u_pm3 (
      .clk(clk), .rst_n(rst_n), .in(in), .clr_ovf(clr_ovf),
      .q(dq[1]), .busy(dbusy[1]), .pend(p1), .ovf(dovf[1])
   );

   pulse_stretcher #(.GAP(0)) u_gap0 (
      .clk(clk), .rst_n(rst_n), .in(in), .clr_ovf(clr_ovf),
      .q(dq[2]), .busy(dbusy[2]), .pend(p2), .ovf(dovf[2])
   );

   always #5 clk = ~clk;

   typedef struct {
      int inst;
      int evt;
      int st;
   } ent_t;

   typedef struct {
      int cyc;
      bit q    [NI];
      bit busy [NI];
      bit ovf  [NI];
      int pend [NI];
   } exp_t;

   ent_t sched [$];
   exp_t expq  [$];
   int   last_st [NI];
   bit   ovf_m   [NI];
   int   cyc = 0;
   int   nvec = 0;
   int   nerr = 0;

   task automatic model_reset();
      sched.delete();
      for (int i = 0; i < NI; i++) begin
         last_st[i] = -1000;
         ovf_m[i]   = 1'b0;
      end
   endtask

   // Expected outputs for the current cycle follow from events of earlier cycles only.
   task automatic push_expect();
      exp_t e;
      e.cyc = cyc;
      for (int i = 0; i < NI; i++) begin
         e.q[i]    = 1'b0;
         e.busy[i] = 1'b0;
         e.pend[i] = 0;
         e.ovf[i]  = ovf_m[i];
         foreach (sched[k]) begin
            if (sched[k].inst == i) begin
               if (sched[k].st <= cyc && cyc < sched[k].st + PW_A[i]) e.q[i] = 1'b1;
               if (sched[k].st <= cyc && cyc < sched[k].st + PW_A[i] + PG_A[i]) e.busy[i] = 1'b1;
               if (sched[k].evt < cyc && sched[k].st > cyc) e.pend[i]++;
            end
         end
      end
      expq.push_back(e);
   endtask

   // Each accepted event schedules one pulse at the earliest legal start; it is dropped when the
   // number of events still waiting after this edge is already at the ceiling.
   task automatic model_event(input bit ev, input bit clr);
      for (int i = 0; i < NI; i++) begin
         bit drop;
         int st;
         int cnt;
         drop = 1'b0;
         if (ev) begin
            st = last_st[i] + PW_A[i] + PG_A[i];
            if (st < cyc + 1) st = cyc + 1;
            if (st > cyc + 1) begin
               cnt = 0;
               foreach (sched[k]) begin
                  if (sched[k].inst == i && sched[k].st > cyc + 1) cnt++;
               end
               if (cnt >= PM_A[i]) drop = 1'b1;
            end
            if (!drop) begin
               sched.push_back('{inst: i, evt: cyc, st: st});
               last_st[i] = st;
            end
         end
         if (drop) ovf_m[i] = 1'b1;
         else if (clr) ovf_m[i] = 1'b0;
      end
      while (sched.size() > 0 && sched[0].st + 8 < cyc) begin
         void'(sched.pop_front());
      end
   endtask

   task automatic step(input bit ev, input bit clr);
      @(posedge clk);
      #1;
      in      = ev;
      clr_ovf = clr;
      cyc++;
      if (!rst_n) begin
         #1 rst_n = 1'b1;
      end
      push_expect();
      model_event(ev, clr);
   endtask

   // Assert reset mid-cycle so the check at the following negedge sees the asynchronous clear.
   task automatic reset_pulse();
      @(posedge clk);
      #1;
      in      = 1'b0;
      clr_ovf = 1'b0;
      cyc++;
      #2 rst_n = 1'b0;
      model_reset();
      push_expect();
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0);
   endtask

   task automatic check(input string nm, input int i, input int c, input int got, input int want);
      nvec++;
      if (got != want) begin
         nerr++;
         $display("FAIL %s[%0d] cycle %0d: got %0d, expected %0d", nm, i, c, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (expq.size() > 0) begin
         exp_t e;
         int   pact [NI];
         e = expq.pop_front();
         pact[0] = int'(p0);
         pact[1] = int'(p1);
         pact[2] = int'(p2);
         for (int i = 0; i < NI; i++) begin
            check("q",    i, e.cyc, int'(dq[i]),    int'(e.q[i]));
            check("busy", i, e.cyc, int'(dbusy[i]), int'(e.busy[i]));
            check("pend", i, e.cyc, pact[i],        e.pend[i]);
            check("ovf",  i, e.cyc, int'(dovf[i]),  int'(e.ovf[i]));
         end
      end
   end

   initial begin
      int dens [6];
      dens = '{5, 20, 45, 70, 90, 100};
      model_reset();
      reset_pulse();
      idle(3);

      // single strobe
      step(1'b1, 1'b0);
      idle(12);

      // three consecutive strobes
      repeat (3) step(1'b1, 1'b0);
      idle(24);

      // level held six cycles saturates the small queue, then clear
      repeat (6) step(1'b1, 1'b0);
      idle(30);
      step(1'b0, 1'b1);
      idle(3);

      // full queue with a strobe on the gap-exit cycle
      repeat (4) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      idle(40);

      // reset mid-pulse, then a fresh strobe
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      reset_pulse();
      reset_pulse();
      step(1'b1, 1'b0);
      idle(12);

      // two strobes back to back
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      idle(14);

      // set and clear of ovf on the same cycle
      repeat (10) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      idle(60);

      for (int ph = 0; ph < 6; ph++) begin
         repeat (500) begin
            bit ev;
            bit clr;
            ev  = ($urandom_range(99) < dens[ph]);
            clr = ($urandom_range(31) == 0);
            if ($urandom_range(399) == 0) reset_pulse();
            else step(ev, clr);
         end
      end
      idle(60);

      repeat (2) @(negedge clk);
      #1;
      if (expq.size() != 0) begin
         nvec++;
         nerr++;
         $display("FAIL drain: %0d expectations left, expected 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
